// File: rtl/dsp_fetch_pkg.sv
// Shared definitions for the DSP receiver fetch stage: word widths, NOP encoding, FSM state codes.
package dsp_fetch_pkg;

    localparam int MEM_ADDR_LEN  = 16;
    localparam int INST_WORD_LEN = 32;

    localparam logic [INST_WORD_LEN-1:0] INST_NOP = 32'h0;

    localparam logic [1:0] FETCH_FILL  = 2'd0;
    localparam logic [1:0] FETCH_RUN   = 2'd1;
    localparam logic [1:0] FETCH_STALL = 2'd2;

    typedef struct packed {
        logic [MEM_ADDR_LEN-1:0]  pc;
        logic [INST_WORD_LEN-1:0] inst;
    } fetch_word_t;

endpackage

// File: rtl/dsp_fetch.sv
// Instruction fetch: owns the PC, drives a 1-cycle synchronous instruction memory,
// holds the presented word under stall and squashes to NOP on an execute redirect.
module dsp_fetch
    import dsp_fetch_pkg::*;
#(
    parameter int                ADDR_W   = MEM_ADDR_LEN,
    parameter int                INST_W   = INST_WORD_LEN,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] instruction,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    output logic [31:0]       fetch_count
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] resp_pc_q;
    logic [INST_W-1:0] hold_inst_q;
    logic [ADDR_W-1:0] hold_pc_q;
    logic [ADDR_W-1:0] pc_next;
    logic              accept;

    // Redirect target wins over sequential advance; wraps modulo 2^ADDR_W.
    assign pc_next   = redirect_en ? redirect_addr : pc_q + ADDR_W'(1);
    assign imem_addr = pc_q;
    assign accept    = inst_valid && !stall && !redirect_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH_FILL;
            pc_q        <= RESET_PC;
            resp_pc_q   <= '0;
            hold_inst_q <= '0;
            hold_pc_q   <= '0;
            fetch_count <= '0;
        end else begin
            if (accept)
                fetch_count <= fetch_count + 32'd1;
            case (state)
                FETCH_FILL: begin
                    pc_q      <= pc_next;
                    resp_pc_q <= pc_q;
                    state     <= redirect_en ? FETCH_FILL : FETCH_RUN;
                end
                FETCH_RUN, FETCH_STALL: begin
                    if (redirect_en) begin
                        pc_q      <= pc_next;
                        resp_pc_q <= pc_q;
                        state     <= FETCH_FILL;
                    end else if (stall) begin
                        // Only the entering cycle captures; memory keeps re-reading pc_q meanwhile.
                        if (state == FETCH_RUN) begin
                            hold_inst_q <= imem_rdata;
                            hold_pc_q   <= resp_pc_q;
                        end
                        state <= FETCH_STALL;
                    end else begin
                        pc_q      <= pc_next;
                        resp_pc_q <= pc_q;
                        state     <= FETCH_RUN;
                    end
                end
                default: state <= FETCH_FILL;
            endcase
        end
    end

    always_comb begin
        instruction = INST_W'(INST_NOP);
        inst_pc     = resp_pc_q;
        inst_valid  = 1'b0;
        case (state)
            FETCH_RUN: begin
                instruction = imem_rdata;
                inst_valid  = 1'b1;
            end
            FETCH_STALL: begin
                instruction = hold_inst_q;
                inst_pc     = hold_pc_q;
                inst_valid  = 1'b1;
            end
            default: ;
        endcase
        if (redirect_en) begin
            instruction = INST_W'(INST_NOP);
            inst_valid  = 1'b0;
        end
    end

endmodule

// File: tb/tb_dsp_fetch.sv
// Scoreboard bench for dsp_fetch: stimulus queues the words decode should accept,
// a negedge monitor pops and compares each handed-off word.
module tb_dsp_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_en;
    logic [15:0] redirect_addr;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [15:0] inst_pc;
    logic        inst_valid;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t exp_q[$];

    dsp_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect_en  (redirect_en),
        .redirect_addr(redirect_addr),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .inst_pc      (inst_pc),
        .inst_valid   (inst_valid),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    // Synchronous 1-cycle ROM with mem[i] = i + 1.
    always @(posedge clk) imem_rdata <= {16'h0, imem_addr} + 32'd1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] pc, input logic [31:0] inst);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_bubble(input string name);
        @(negedge clk);
        check({name, "_valid"}, 64'(inst_valid), 64'd0);
        check({name, "_nop"}, 64'(instruction), 64'h0);
    endtask

    task automatic check_held(input string name, input logic [15:0] pc, input logic [31:0] inst);
        @(negedge clk);
        check({name, "_valid"}, 64'(inst_valid), 64'd1);
        check({name, "_pc"}, 64'(inst_pc), 64'(pc));
        check({name, "_inst"}, 64'(instruction), 64'(inst));
    endtask

    // Monitor: every word decode accepts must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && inst_valid && !stall && !redirect_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word_pc", 64'(inst_pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("word_pc", 64'(inst_pc), 64'(e.pc));
                check("word_inst", 64'(instruction), 64'(e.inst));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_addr = 16'h0;

        // Test 1: reset then free-run
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst", 64'(instruction), 64'h0);
        check("rst_pc", 64'(inst_pc), 64'h0);
        check("rst_addr", 64'(imem_addr), 64'h0);
        check("rst_count", 64'(fetch_count), 64'd0);
        for (int i = 0; i < 9; i++) push(16'(i), 32'(i + 1));

        // Test 2: stall three cycles while pc 5 is presented
        step(6);
        stall = 1'b1;
        check_held("stall0", 16'h5, 32'h6);
        check("stall_count", 64'(fetch_count), 64'd5);
        step(1);
        check_held("stall1", 16'h5, 32'h6);
        step(1);
        check_held("stall2", 16'h5, 32'h6);
        step(1);
        stall = 1'b0;
        step(1);
        @(negedge clk);
        check("release_count", 64'(fetch_count), 64'd6);

        // Test 3: redirect to 0x40 while pc 9 is presented
        step(3);
        redirect_en = 1'b1; redirect_addr = 16'h0040;
        check_bubble("redir_sq");
        check("redir_count", 64'(fetch_count), 64'd9);
        step(1);
        redirect_en = 1'b0;
        check_bubble("redir_fill");
        push(16'h0040, 32'h41);
        push(16'h0041, 32'h42);

        // Test 4: redirect and stall together in STALL; held 0x42 is dropped
        step(3);
        stall = 1'b1;
        step(1);
        redirect_en = 1'b1; redirect_addr = 16'h0080;
        check_bubble("rs_sq");
        step(1);
        stall = 1'b0; redirect_en = 1'b0;
        check_bubble("rs_fill");
        push(16'h0080, 32'h81);
        push(16'h0081, 32'h82);

        // Test 5: redirect near the top of the address space and wrap
        step(3);
        redirect_en = 1'b1; redirect_addr = 16'hFFFE;
        check_bubble("wrap_sq");
        step(1);
        redirect_en = 1'b0;
        push(16'hFFFE, 32'h0000_FFFF);
        push(16'hFFFF, 32'h0001_0000);
        push(16'h0000, 32'h1);
        push(16'h0001, 32'h2);

        // Test 6: reset in the middle of a stall
        step(5);
        stall = 1'b1;
        @(negedge clk);
        check("pre_rst_count", 64'(fetch_count), 64'd17);
        step(1);
        rst = 1'b1;
        check_held("pre_rst_held", 16'h2, 32'h3);
        step(1);
        rst = 1'b0; stall = 1'b0;
        @(negedge clk);
        check("rst2_valid", 64'(inst_valid), 64'd0);
        check("rst2_count", 64'(fetch_count), 64'd0);
        check("rst2_addr", 64'(imem_addr), 64'h0);
        push(16'h0, 32'h1);
        push(16'h1, 32'h2);
        push(16'h2, 32'h3);
        step(4);
        stall = 1'b1;
        @(negedge clk);
        check("final_count", 64'(fetch_count), 64'd3);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
